// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo
//   Single-clock audio sample FIFO sitting between the audio clock-domain
//   crossing and the audio sample packet generator. One multi-channel sample
//   is accepted per sample_valid strobe. Each packet_request pops up to
//   PARALLEL_OUT samples into a registered packet with per-slot presence flags.
//   Overflow drops the incoming sample and sets a sticky flag. Stored contents
//   are never cleared.
//
//   Optional feature macro: AUDIO_FIFO_STATS_EN
//     defined     : dropped_count / short_count are saturating 16-bit counters
//     not defined : both counters are tied to zero
//
// Ports
//   clk_pixel       in   pixel clock, all logic
//   reset           in   synchronous, active-high
//   sample_valid    in   audio_in carries a new sample this cycle
//   audio_in        in   [CHANNELS][BIT_WIDTH] sample word
//   packet_request  in   pop up to PARALLEL_OUT samples
//   audio_out       out  [PARALLEL_OUT][CHANNELS][BIT_WIDTH] registered packet
//   sample_present  out  slot i of audio_out holds a real sample
//   packet_valid    out  one-cycle pulse, audio_out/sample_present valid
//   level           out  samples stored
//   full / empty    out  level == BUFFER_SIZE / level == 0
//   overflow        out  sticky, a sample was dropped
//   dropped_count   out  dropped-sample counter (stats build only)
//   short_count     out  short-packet counter (stats build only)
module audio_sample_fifo #(
    parameter int BUFFER_SIZE  = 128,
    parameter int BIT_WIDTH    = 24,
    parameter int CHANNELS     = 2,
    parameter int PARALLEL_OUT = 4
) (
    input  logic                                                  clk_pixel,
    input  logic                                                  reset,
    input  logic                                                  sample_valid,
    input  logic [CHANNELS-1:0][BIT_WIDTH-1:0]                    audio_in,
    input  logic                                                  packet_request,
    output logic [PARALLEL_OUT-1:0][CHANNELS-1:0][BIT_WIDTH-1:0]  audio_out,
    output logic [PARALLEL_OUT-1:0]                               sample_present,
    output logic                                                  packet_valid,
    output logic [$clog2(BUFFER_SIZE):0]                          level,
    output logic                                                  full,
    output logic                                                  empty,
    output logic                                                  overflow,
    output logic [15:0]                                           dropped_count,
    output logic [15:0]                                           short_count
);

    localparam int AW = $clog2(BUFFER_SIZE);
    localparam int PW = AW + 1;

    typedef logic [CHANNELS-1:0][BIT_WIDTH-1:0] word_t;

    word_t          mem [BUFFER_SIZE];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  pop_n;
    logic           wr_en;
    logic           drop;
    logic [AW-1:0]  rd_addr [PARALLEL_OUT];

    // Extra wrap bit on both pointers lets level distinguish full from empty.
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == PW'(BUFFER_SIZE));
    assign empty = (level == '0);

    // full is the pre-pop state, so a pop in the same cycle cannot make room.
    assign wr_en = sample_valid && !full;
    assign drop  = sample_valid && full;

    // Number of samples taken by a request; a same-cycle write is not counted.
    always_comb begin
        pop_n = level;
        if (level > PW'(PARALLEL_OUT)) begin
            pop_n = PW'(PARALLEL_OUT);
        end
    end

    // Read addresses wrap naturally by truncating to the array index width.
    always_comb begin
        for (int unsigned i = 0; i < PARALLEL_OUT; i++) begin
            rd_addr[i] = rd_ptr[AW-1:0] + AW'(i);
        end
    end

    // Storage has no reset so it can map onto RAM; reset only moves pointers.
    always_ff @(posedge clk_pixel) begin
        if (!reset && wr_en) begin
            mem[wr_ptr[AW-1:0]] <= audio_in;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            audio_out      <= '0;
            sample_present <= '0;
            packet_valid   <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            packet_valid <= packet_request;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (packet_request) begin
                for (int unsigned i = 0; i < PARALLEL_OUT; i++) begin
                    if (PW'(i) < pop_n) begin
                        audio_out[i]      <= mem[rd_addr[i]];
                        sample_present[i] <= 1'b1;
                    end else begin
                        audio_out[i]      <= '0;
                        sample_present[i] <= 1'b0;
                    end
                end
                rd_ptr <= rd_ptr + pop_n;
            end
        end
    end

`ifdef AUDIO_FIFO_STATS_EN
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            dropped_count <= '0;
            short_count   <= '0;
        end else begin
            if (drop && (dropped_count != '1)) begin
                dropped_count <= dropped_count + 1'b1;
            end
            if (packet_request && (pop_n < PW'(PARALLEL_OUT)) && (short_count != '1)) begin
                short_count <= short_count + 1'b1;
            end
        end
    end
`else
    assign dropped_count = '0;
    assign short_count   = '0;
`endif

endmodule

// File: tb/tb_audio_sample_fifo.sv
module tb_audio_sample_fifo;

    localparam int BS = 8;
    localparam int BW = 24;
    localparam int CH = 2;
    localparam int PO = 4;

    typedef logic [CH-1:0][BW-1:0] word_t;

    typedef struct {
        int unsigned               tag;
        logic                      pv;
        logic [PO-1:0][CH*BW-1:0]  out;
        logic [PO-1:0]             pres;
        int unsigned               lvl;
        logic                      ovf;
        int unsigned               drop;
        int unsigned               shrt;
    } exp_t;

    logic                             clk_pixel = 1'b0;
    logic                             reset = 1'b1;
    logic                             sample_valid = 1'b0;
    word_t                            audio_in = '0;
    logic                             packet_request = 1'b0;
    logic [PO-1:0][CH-1:0][BW-1:0]    audio_out;
    logic [PO-1:0]                    sample_present;
    logic                             packet_valid;
    logic [$clog2(BS):0]              level;
    logic                             full;
    logic                             empty;
    logic                             overflow;
    logic [15:0]                      dropped_count;
    logic [15:0]                      short_count;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned edge_cnt = 0;

    exp_t  expq [$];
    exp_t  mon_e;

    // Reference model state: the FIFO contents as a plain queue.
    word_t                     mq [$];
    logic [PO-1:0][CH*BW-1:0]  m_out = '0;
    logic [PO-1:0]             m_pres = '0;
    logic                      m_ovf = 1'b0;
    int unsigned               m_drop = 0;
    int unsigned               m_short = 0;

    audio_sample_fifo #(
        .BUFFER_SIZE (BS),
        .BIT_WIDTH   (BW),
        .CHANNELS    (CH),
        .PARALLEL_OUT(PO)
    ) dut (
        .clk_pixel     (clk_pixel),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .audio_in      (audio_in),
        .packet_request(packet_request),
        .audio_out     (audio_out),
        .sample_present(sample_present),
        .packet_valid  (packet_valid),
        .level         (level),
        .full          (full),
        .empty         (empty),
        .overflow      (overflow),
        .dropped_count (dropped_count),
        .short_count   (short_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    always @(posedge clk_pixel) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    function automatic word_t mk(input int unsigned k);
        return {BW'(k + 1000), BW'(k)};
    endfunction

    // Apply one cycle of inputs, advance the model by the same cycle and queue
    // the state the DUT should show after the coming clock edge.
    task automatic step(input bit r, input bit sv, input bit req, input word_t din);
        exp_t        e;
        int unsigned lvl;
        int unsigned n;
        reset          = r;
        sample_valid   = sv;
        packet_request = req;
        audio_in       = din;
        e.pv = 1'b0;
        if (r) begin
            mq.delete();
            m_out   = '0;
            m_pres  = '0;
            m_ovf   = 1'b0;
            m_drop  = 0;
            m_short = 0;
        end else begin
            lvl  = mq.size();
            n    = (lvl < PO) ? lvl : PO;
            e.pv = req;
            if (req) begin
                for (int i = 0; i < PO; i++) begin
                    m_out[i] = (i < n) ? mq[i] : '0;
                end
                m_pres = PO'((1 << n) - 1);
                for (int i = 0; i < n; i++) begin
                    void'(mq.pop_front());
                end
                if (n < PO && m_short < 65535) m_short++;
            end
            if (sv) begin
                if (lvl == BS) begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end else begin
                    mq.push_back(din);
                end
            end
        end
        e.tag  = edge_cnt + 1;
        e.out  = m_out;
        e.pres = m_pres;
        e.lvl  = mq.size();
        e.ovf  = m_ovf;
`ifdef AUDIO_FIFO_STATS_EN
        e.drop = m_drop;
        e.shrt = m_short;
`else
        e.drop = 0;
        e.shrt = 0;
`endif
        expq.push_back(e);
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic idle(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic write_n(input int unsigned cnt, input int unsigned base);
        for (int unsigned i = 0; i < cnt; i++) step(1'b0, 1'b1, 1'b0, mk(base + i));
    endtask

    // Monitor: compares every queued expectation against the DUT once its edge has passed.
    always @(negedge clk_pixel) begin
        while (expq.size() > 0 && expq[0].tag <= edge_cnt) begin
            mon_e = expq.pop_front();
            check("edge_tag",       192'(mon_e.tag),  192'(edge_cnt));
            check("packet_valid",   192'(packet_valid), 192'(mon_e.pv));
            if (packet_valid || mon_e.pv) begin
                check("sample_present", 192'(sample_present), 192'(mon_e.pres));
            end
            check("audio_out",      192'(audio_out),  192'(mon_e.out));
            check("level",          192'(level),      192'(mon_e.lvl));
            check("full",           192'(full),       192'(mon_e.lvl == BS));
            check("empty",          192'(empty),      192'(mon_e.lvl == 0));
            check("overflow",       192'(overflow),   192'(mon_e.ovf));
            check("dropped_count",  192'(dropped_count), 192'(mon_e.drop));
            check("short_count",    192'(short_count),   192'(mon_e.shrt));
        end
    end

    initial begin
        int unsigned sv_pct;
        int unsigned rq_pct;
        #1;
        // Reset, three samples, one request: short packet of three.
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        write_n(3, 1);
        step(1'b0, 1'b0, 1'b1, '0);
        idle(2);

        // Ten writes into an 8-deep FIFO: two dropped, overflow sticks.
        step(1'b1, 1'b0, 1'b0, '0);
        write_n(10, 20);
        idle(2);

        // Wrap: move rd_ptr to 6, refill with 6, then three requests.
        step(1'b1, 1'b0, 1'b0, '0);
        write_n(6, 40);
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        write_n(6, 60);
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        idle(1);

        // Request at level 2 with a same-cycle write.
        step(1'b1, 1'b0, 1'b0, '0);
        write_n(2, 80);
        step(1'b0, 1'b1, 1'b1, mk(90));
        idle(1);

        // Reset wins over a same-cycle write and request.
        write_n(4, 100);
        step(1'b0, 1'b1, 1'b0, mk(104));
        step(1'b1, 1'b1, 1'b1, mk(105));
        idle(2);

        // Randomised traffic with shifting write/read pressure.
        for (int unsigned seg = 0; seg < 12; seg++) begin
            sv_pct = (seg % 3 == 0) ? 90 : ((seg % 3 == 1) ? 30 : 60);
            rq_pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 20);
            for (int unsigned c = 0; c < 150; c++) begin
                step($urandom_range(0, 249) == 0,
                     $urandom_range(0, 99) < sv_pct,
                     $urandom_range(0, 99) < rq_pct,
                     word_t'(48'({$urandom(), $urandom()})));
            end
        end
        idle(3);
        @(posedge clk_pixel);
        #2;
        check("scoreboard_drained", 192'(expq.size()), 192'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
